// File: rtl/timeout_scheduler.sv
// rtl/timeout_scheduler.sv - multi-channel tick-based timeout scheduler with round-robin expiry events
// Define TIMEOUT_SCHEDULER_TICK_IN_EN to take the tick from tick_in instead of the internal prescaler.
module timeout_scheduler #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 12500000
) (
  input  logic                   clk,
  input  logic                   rstn,
`ifdef TIMEOUT_SCHEDULER_TICK_IN_EN
  input  logic                   tick_in,
`endif
  input  logic                   arm_valid,
  output logic                   arm_ready,
  input  logic [$clog2(NCH)-1:0] arm_ch,
  input  logic [WIDTH-1:0]       arm_ticks,
  input  logic [NCH-1:0]         cancel,
  output logic [NCH-1:0]         active,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [$clog2(NCH)-1:0] evt_ch,
  output logic [WIDTH-1:0]       now
);
  localparam int CW = $clog2(NCH);

  typedef enum logic {S_IDLE, S_PRESENT} state_e;

  state_e           state_q, state_d;
  logic             tick;
  logic [WIDTH-1:0] now_q;
  logic [WIDTH-1:0] rem_q [NCH];
  logic [WIDTH-1:0] rem_d [NCH];
  logic [NCH-1:0]   active_q, active_d, pend_q, pend_d, cand;
  logic [CW-1:0]    rr_q, rr_d, evt_ch_q, evt_ch_d, scan_idx;
  logic             arm_fire, evt_fire, found;

`ifdef TIMEOUT_SCHEDULER_TICK_IN_EN
  assign tick = tick_in;
`else
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q;

  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     now_q <= '0;
    else if (tick) now_q <= now_q + WIDTH'(1);
  end

  assign arm_ready = ~pend_q[arm_ch];
  assign arm_fire  = arm_valid & arm_ready;
  assign evt_fire  = (state_q == S_PRESENT) & evt_ready;

  // Later assignments take priority: handshake < expiry < cancel < arm.
  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    rem_d    = rem_q;
    if (evt_fire) pend_d[evt_ch_q] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (tick && active_q[i]) begin
        if (rem_q[i] == WIDTH'(1)) begin
          rem_d[i]    = '0;
          active_d[i] = 1'b0;
          pend_d[i]   = 1'b1;
        end else begin
          rem_d[i] = rem_q[i] - WIDTH'(1);
        end
      end
      if (cancel[i]) begin
        active_d[i] = 1'b0;
        pend_d[i]   = 1'b0;
      end
      if (arm_fire && (arm_ch == CW'(i))) begin
        if (arm_ticks != '0) begin
          rem_d[i]    = arm_ticks;
          active_d[i] = 1'b1;
        end else begin
          rem_d[i]    = '0;
          active_d[i] = 1'b0;
          pend_d[i]   = 1'b1;
        end
      end
    end
  end

  // Channels cancelled this cycle are not eligible to be presented.
  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    rr_d     = rr_q;
    cand     = pend_q & ~cancel;
    found    = 1'b0;
    scan_idx = '0;
    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < NCH; k++) begin
          scan_idx = CW'((int'(rr_q) + k) % NCH);
          if (!found && cand[scan_idx]) begin
            found    = 1'b1;
            evt_ch_d = scan_idx;
          end
        end
        if (found) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (evt_ready) begin
          rr_d    = (evt_ch_q == CW'(NCH - 1)) ? '0 : evt_ch_q + CW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      pend_q   <= '0;
      rr_q     <= '0;
      evt_ch_q <= '0;
      for (int i = 0; i < NCH; i++) rem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      evt_ch_q <= evt_ch_d;
      for (int i = 0; i < NCH; i++) rem_q[i] <= rem_d[i];
    end
  end

  assign active    = active_q;
  assign evt_valid = (state_q == S_PRESENT);
  assign evt_ch    = evt_ch_q;
  assign now       = now_q;

endmodule

// File: tb/tb_timeout_scheduler.sv
// tb/tb_timeout_scheduler.sv - directed and randomized checks of timeout_scheduler against a deadline-based model
module tb_timeout_scheduler;
  localparam int NCH      = 4;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       arm_valid = 1'b0;
  logic       arm_ready;
  logic [1:0] arm_ch = '0;
  logic [7:0] arm_ticks = '0;
  logic [3:0] cancel = '0;
  logic [3:0] active;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic [7:0] now;

  int checks   = 0;
  int failures = 0;

  // Model: channels hold an absolute tick deadline rather than a down-counter.
  int m_ticks, m_presc, m_rr, m_evch;
  int m_deadline [NCH];
  bit m_active [NCH];
  bit m_pend [NCH];
  bit m_present;

  timeout_scheduler #(.NCH(NCH), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rstn(rstn),
    .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_ch(arm_ch), .arm_ticks(arm_ticks),
    .cancel(cancel), .active(active),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .now(now)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ticks = 0; m_presc = 0; m_rr = 0; m_evch = 0; m_present = 0;
    for (int i = 0; i < NCH; i++) begin
      m_deadline[i] = 0; m_active[i] = 0; m_pend[i] = 0;
    end
  endtask

  function automatic logic [3:0] act_vec();
    logic [3:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_active[i];
    return v;
  endfunction

  // Called at a negedge with inputs already driven; compares, advances model, waits one cycle.
  task automatic step();
    bit tick, hs, fire;
    int hs_ch, c;
    bit op [NCH];
    #1;
    chk("evt_valid", 32'(evt_valid), 32'(m_present));
    chk("evt_ch", 32'(evt_ch), 32'(m_evch));
    chk("active", 32'(active), 32'(act_vec()));
    chk("now", 32'(now), 32'(m_ticks % 256));
    chk("arm_ready", 32'(arm_ready), 32'(!m_pend[arm_ch]));
    tick  = (m_presc == PRESCALE - 1);
    hs    = m_present && evt_ready;
    hs_ch = m_evch;
    fire  = arm_valid && !m_pend[arm_ch];
    for (int i = 0; i < NCH; i++) op[i] = m_pend[i];
    for (int i = 0; i < NCH; i++) begin
      if (hs && i == hs_ch) m_pend[i] = 0;
      if (tick && m_active[i] && (m_ticks + 1 == m_deadline[i])) begin
        m_active[i] = 0; m_pend[i] = 1;
      end
      if (cancel[i]) begin
        m_active[i] = 0; m_pend[i] = 0;
      end
      if (fire && int'(arm_ch) == i) begin
        if (arm_ticks != 0) begin
          m_active[i] = 1;
          m_deadline[i] = m_ticks + int'(tick) + int'(arm_ticks);
        end else begin
          m_active[i] = 0; m_pend[i] = 1;
        end
      end
    end
    if (m_present) begin
      if (evt_ready) begin
        m_present = 0;
        m_rr = (m_evch + 1) % NCH;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (!m_present && op[c] && !cancel[c]) begin
          m_present = 1; m_evch = c;
        end
      end
    end
    m_ticks += int'(tick);
    m_presc = (m_presc + 1) % PRESCALE;
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks outputs clear before any edge arrives.
  task automatic do_reset();
    arm_valid = 0; cancel = '0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_evt_ch", 32'(evt_ch), 32'd0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int n, seen2;
    int ev_ch[$];
    int ev_cyc[$];
    rstn = 1'b1;
    m_reset();
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_arm_ready", 32'(arm_ready), 32'd1);
    rstn = 1'b1;

    // ch2, 3 ticks, armed right at reset release
    evt_ready = 1; arm_valid = 1; arm_ch = 2; arm_ticks = 3;
    step();
    arm_valid = 0;
    n = 0;
    while (!evt_valid && n < 40) begin step(); n++; end
    chk("r032_seen", 32'(evt_valid), 32'd1);
    chk("r032_ch", 32'(evt_ch), 32'd2);
    chk("r032_now", 32'(now), 32'd3);
    chk("r032_inactive", 32'(active[2]), 32'd0);
    step();

    // ch0, ch1, ch3 expire on the same tick; round-robin from 0
    do_reset();
    arm_valid = 1; arm_ticks = 1;
    arm_ch = 0; step();
    arm_ch = 1; step();
    arm_ch = 3; step();
    arm_valid = 0;
    for (int c = 0; c < 14; c++) begin
      if (evt_valid) begin ev_ch.push_back(int'(evt_ch)); ev_cyc.push_back(c); end
      step();
    end
    chk("r033_count", 32'(ev_ch.size()), 32'd3);
    if (ev_ch.size() == 3) begin
      chk("r033_first", 32'(ev_ch[0]), 32'd0);
      chk("r033_second", 32'(ev_ch[1]), 32'd1);
      chk("r033_third", 32'(ev_ch[2]), 32'd3);
      chk("r033_gap1", 32'(ev_cyc[1] - ev_cyc[0]), 32'd2);
      chk("r033_gap2", 32'(ev_cyc[2] - ev_cyc[1]), 32'd2);
    end

    // backpressure on a ch1 event; re-arm of ch1 blocked meanwhile
    evt_ready = 0; arm_valid = 1; arm_ch = 1; arm_ticks = 0;
    step();
    arm_ticks = 5;
    step();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("r034_valid", 32'(evt_valid), 32'd1);
      chk("r034_ch", 32'(evt_ch), 32'd1);
      chk("r034_blocked", 32'(arm_ready), 32'd0);
      step();
    end
    evt_ready = 1;
    step();
    step();
    arm_valid = 0;
    step();
    chk("r034_rearmed", 32'(active[1]), 32'd1);

    // cancel mid-count, then a zero-length timeout
    cancel = 4'b0010; step(); cancel = '0;
    arm_valid = 1; arm_ch = 2; arm_ticks = 5; step(); arm_valid = 0;
    for (int c = 0; c < 8; c++) step();
    cancel = 4'b0100; step(); cancel = '0;
    chk("r035_cancelled", 32'(active[2]), 32'd0);
    arm_valid = 1; arm_ch = 3; arm_ticks = 0; step(); arm_valid = 0;
    step();
    chk("r035_zero_valid", 32'(evt_valid), 32'd1);
    chk("r035_zero_ch", 32'(evt_ch), 32'd3);
    seen2 = 0;
    for (int c = 0; c < 30; c++) begin
      if (evt_valid && evt_ch == 2) seen2++;
      step();
    end
    chk("r035_no_ch2_evt", 32'(seen2), 32'd0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      arm_valid = ($urandom_range(3) == 0);
      arm_ch    = 2'($urandom_range(3));
      arm_ticks = 8'($urandom_range(3));
      cancel    = ($urandom_range(15) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0;
      evt_ready = ($urandom_range(2) != 0);
      step();
    end
    arm_valid = 0; cancel = '0; evt_ready = 1;

    // reset mid-count, then a full wrap of now
    arm_valid = 1; arm_ch = 0; arm_ticks = 2; step(); arm_valid = 0;
    step(); step(); step();
    do_reset();
    n = 0;
    for (int c = 0; c < 1023; c++) begin
      if (evt_valid) n++;
      step();
    end
    chk("r036_now_255", 32'(now), 32'd255);
    step();
    chk("r036_now_wrap", 32'(now), 32'd0);
    chk("r036_no_evt", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
